// File: rtl/decoder_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decoder_scan_ctrl: walks a 5-bit index first..last with a programmable     |
// | dwell, once or continuously, feeding a 5-to-32 decoder. Optional macro:    |
// | SCAN_PAUSE_EN (adds iPause).                                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module decoder_scan_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic             iStop,
  input  logic             iMode,
  input  logic [4:0]       iFirst,
  input  logic [4:0]       iLast,
  input  logic [DIV_W-1:0] iDiv,
`ifdef SCAN_PAUSE_EN
  input  logic             iPause,
`endif
  output logic [4:0]       oData,
  output logic             oEna,
  output logic             oBusy,
  output logic             oDone,
  output logic             oWrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_stateNxt;
  logic [4:0]       r_data, w_dataNxt;
  logic             r_ena, w_enaNxt;
  logic             r_busy, w_busyNxt;
  logic             r_done, w_doneNxt;
  logic             r_wrap, w_wrapNxt;
  logic [DIV_W-1:0] r_cnt, w_cntNxt;
  logic [4:0]       r_first, r_last;
  logic [DIV_W-1:0] r_div;
  logic             r_mode, r_down;
  logic             w_load;
  logic             w_pause;

`ifdef SCAN_PAUSE_EN
  assign w_pause = iPause;
`else
  assign w_pause = 1'b0;
`endif

  always_comb begin
    w_stateNxt = r_state;
    w_dataNxt  = r_data;
    w_enaNxt   = r_ena;
    w_busyNxt  = r_busy;
    w_cntNxt   = r_cnt;
    w_doneNxt  = 1'b0;
    w_wrapNxt  = 1'b0;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dataNxt = 5'd0;
        w_enaNxt  = 1'b0;
        w_busyNxt = 1'b0;
        w_cntNxt  = '0;
        if (iStart && !iStop) begin
          w_stateNxt = S_RUN;
          w_load     = 1'b1;
          w_dataNxt  = iFirst;
          w_enaNxt   = 1'b1;
          w_busyNxt  = 1'b1;
        end
      end
      S_RUN: begin
        // Stop outranks pause, step, wrap and done.
        if (iStop) begin
          w_stateNxt = S_IDLE;
          w_dataNxt  = 5'd0;
          w_enaNxt   = 1'b0;
          w_busyNxt  = 1'b0;
          w_cntNxt   = '0;
        end else if (!w_pause) begin
          if (r_cnt != r_div) begin
            w_cntNxt = r_cnt + DIV_W'(1);
          end else if (r_data != r_last) begin
            w_dataNxt = r_down ? (r_data - 5'd1) : (r_data + 5'd1);
            w_cntNxt  = '0;
          end else if (r_mode) begin
            w_dataNxt = r_first;
            w_cntNxt  = '0;
            w_wrapNxt = 1'b1;
          end else begin
            w_stateNxt = S_DONE;
            w_dataNxt  = 5'd0;
            w_enaNxt   = 1'b0;
            w_busyNxt  = 1'b0;
            w_cntNxt   = '0;
            w_doneNxt  = 1'b1;
          end
        end
      end
      default: begin
        // DONE lasts one cycle and never accepts a start.
        w_stateNxt = S_IDLE;
        w_dataNxt  = 5'd0;
        w_enaNxt   = 1'b0;
        w_busyNxt  = 1'b0;
        w_cntNxt   = '0;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
      r_data  <= 5'd0;
      r_ena   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNxt;
      r_data  <= w_dataNxt;
      r_ena   <= w_enaNxt;
      r_busy  <= w_busyNxt;
      r_done  <= w_doneNxt;
      r_wrap  <= w_wrapNxt;
      r_cnt   <= w_cntNxt;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_first <= 5'd0;
      r_last  <= 5'd0;
      r_div   <= '0;
      r_mode  <= 1'b0;
      r_down  <= 1'b0;
    end else if (w_load) begin
      r_first <= iFirst;
      r_last  <= iLast;
      r_div   <= iDiv;
      r_mode  <= iMode;
      r_down  <= (iFirst > iLast);
    end
  end

  assign oData = r_data;
  assign oEna  = r_ena;
  assign oBusy = r_busy;
  assign oDone = r_done;
  assign oWrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_decoder_scan_ctrl: directed + random stimulus against a sweep-time model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_decoder_scan_ctrl;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             start = 1'b0, stop = 1'b0, mode = 1'b0, pause = 1'b0;
  logic [4:0]       first = '0, last = '0;
  logic [DIV_W-1:0] div = '0;
  logic [4:0]       oData;
  logic             oEna, oBusy, oDone, oWrap;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.DIV_W(DIV_W)) dut (
    .iClk(clk), .iRst_n(rstN), .iStart(start), .iStop(stop), .iMode(mode),
    .iFirst(first), .iLast(last), .iDiv(div),
`ifdef SCAN_PAUSE_EN
    .iPause(pause),
`endif
    .oData(oData), .oEna(oEna), .oBusy(oBusy), .oDone(oDone), .oWrap(oWrap)
  );

  // Model: a sweep is described by elapsed active time t; index and pulses
  // follow arithmetically from t, the sweep length and the dwell period.
  bit mRun = 0, mDoneCyc = 0, mWrap = 0, mMode = 0;
  int mFirst = 0, mLast = 0, mPer = 1, mLen = 1, mDir = 1, t = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int expData();
    if (!mRun) return 0;
    return mFirst + mDir * ((t / mPer) % mLen);
  endfunction

  task automatic modelReset();
    mRun = 0; mDoneCyc = 0; mWrap = 0; t = 0;
  endtask

  task automatic modelUpdate(input bit s, input bit p, input bit ps);
    mWrap = 0;
    if (mDoneCyc) begin
      mDoneCyc = 0;
    end else if (mRun) begin
      if (p) mRun = 0;
      else if (!ps) begin
        t++;
        if (!mMode && t == mLen * mPer) begin
          mRun = 0; mDoneCyc = 1;
        end else if (mMode && (t % (mLen * mPer)) == 0) begin
          mWrap = 1;
        end
      end
    end else if (s && !p) begin
      mRun = 1; t = 0;
      mFirst = int'(first); mLast = int'(last);
      mPer = int'(div) + 1; mMode = mode;
      mDir = (mFirst <= mLast) ? 1 : -1;
      mLen = (mFirst <= mLast) ? (mLast - mFirst + 1) : (mFirst - mLast + 1);
    end
  endtask

  task automatic compareAll();
    chk("data", 32'(oData), 32'(expData()));
    chk("ena",  32'(oEna),  32'(mRun));
    chk("busy", 32'(oBusy), 32'(mRun));
    chk("done", 32'(oDone), 32'(mDoneCyc));
    chk("wrap", 32'(oWrap), 32'(mWrap));
  endtask

  task automatic step(input bit s, input bit p, input bit ps);
    bit effPause;
    @(negedge clk);
    start = s; stop = p; pause = ps;
`ifdef SCAN_PAUSE_EN
    effPause = ps;
`else
    effPause = 1'b0;
`endif
    modelUpdate(s, p, effPause);
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic cfg(input int f, input int l, input int d, input bit m);
    first = 5'(f); last = 5'(l); div = DIV_W'(d); mode = m;
  endtask

  initial begin
    int upExp[8];
    int wraps;
    int doneSeen;
    int guard;

    upExp = '{2, 2, 3, 3, 4, 4, 5, 5};
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compareAll();
    @(negedge clk);
    rstN = 1'b1;
    step(0, 0, 0);

    // Asynchronous reset mid-sweep while oData=7.
    cfg(5, 10, 0, 0);
    step(1, 0, 0);
    guard = 0;
    while (oData != 5'd7 && guard < 20) begin
      step(0, 0, 0);
      guard++;
    end
    chk("reachSeven", 32'(oData), 32'd7);
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    chk("rstData", 32'(oData), 32'd0);
    chk("rstEna",  32'(oEna),  32'd0);
    chk("rstBusy", 32'(oBusy), 32'd0);
    chk("rstDone", 32'(oDone), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) step(0, 0, 0);

    // Single up-sweep 2..5, div=1.
    cfg(2, 5, 1, 0);
    step(1, 0, 0);
    chk("up0", 32'(oData), 32'(upExp[0]));
    for (int i = 1; i < 8; i++) begin
      step(0, 0, 0);
      chk("upSeq", 32'(oData), 32'(upExp[i]));
      chk("upEna", 32'(oEna), 32'd1);
    end
    step(0, 0, 0);
    chk("upDone", 32'(oDone), 32'd1);
    chk("upDoneEna", 32'(oEna), 32'd0);
    step(0, 0, 0);

    // Continuous down-sweep 31..29, div=0.
    cfg(31, 29, 0, 1);
    step(1, 0, 0);
    chk("dn0", 32'(oData), 32'd31);
    wraps = 0; doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      wraps += int'(oWrap);
      doneSeen += int'(oDone);
    end
    chk("dnWraps", 32'(wraps), 32'd2);
    chk("dnNoDone", 32'(doneSeen), 32'd0);
    step(0, 1, 0);

    // Stop at index 4 of 0..9, then start+stop together in IDLE.
    cfg(0, 9, 0, 0);
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    chk("preStop", 32'(oData), 32'd4);
    step(0, 1, 0);
    chk("stopData", 32'(oData), 32'd0);
    chk("stopDone", 32'(oDone), 32'd0);
    step(1, 1, 0);
    chk("startStop", 32'(oBusy), 32'd0);

    // Degenerate 17..17, div=3, start held high throughout.
    cfg(17, 17, 3, 0);
    step(1, 0, 0);
    repeat (3) begin
      step(1, 0, 0);
      chk("degData", 32'(oData), 32'd17);
    end
    step(1, 0, 0);
    chk("degDone", 32'(oDone), 32'd1);
    step(1, 0, 0);
    chk("degIdle", 32'(oEna), 32'd0);
    step(1, 0, 0);
    chk("degRestart", 32'(oBusy), 32'd1);
    step(0, 1, 0);

`ifdef SCAN_PAUSE_EN
    cfg(0, 9, 0, 0);
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    repeat (5) begin
      step(0, 0, 1);
      chk("pauseHold", 32'(oData), 32'd3);
    end
    step(0, 0, 0);
    chk("pauseResume", 32'(oData), 32'd4);
    step(0, 1, 0);
`endif

    // Random traffic; config inputs keep changing to exercise latching.
    for (int i = 0; i < 4000; i++) begin
      cfg($urandom_range(31), $urandom_range(31), $urandom_range(3), 1'($urandom_range(1)));
      step($urandom_range(99) < 30, $urandom_range(99) < 3, $urandom_range(99) < 20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
